// File: rtl/priority_pkg.sv
// priority_pkg: shared index/one-hot types for the priority encoder/decoder family
package priority_pkg;
   localparam int IDX_W = 3;
   localparam int OUT_W = 2 ** IDX_W;
   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [OUT_W-1:0] onehot_t;
   function automatic onehot_t idx_to_onehot(idx_t idx);
      return onehot_t'(1) << idx;
   endfunction
endpackage

// File: rtl/priority_decoder_buf_if.sv
// priority_decoder_buf_if: index-in / one-hot-out handshake bundle
interface priority_decoder_buf_if import priority_pkg::*; #(parameter int DEPTH = 4);
   localparam int CNT_W = $clog2(DEPTH + 1);
   idx_t             In;
   logic             InValid;
   logic             InReady;
   onehot_t          Out;
   logic             OutValid;
   logic             OutReady;
   onehot_t          Pending;
   logic [CNT_W-1:0] Count;
   modport slave (input In, InValid, OutReady, output InReady, Out, OutValid, Pending, Count);
   modport master (output In, InValid, OutReady, input InReady, Out, OutValid, Pending, Count);
endinterface

// File: rtl/priority_decoder_buf_onehot_decoder.sv
// onehot_decoder: combinational index to one-hot expansion
module onehot_decoder import priority_pkg::*; (
   input  idx_t    idx_i,
   output onehot_t onehot_o
);
   assign onehot_o = idx_to_onehot(idx_i);
endmodule

// File: rtl/priority_decoder_buf.sv
// priority_decoder_buf: FIFO of encoded indices presented as one-hot vectors
module priority_decoder_buf import priority_pkg::*; #(parameter int DEPTH = 4) (
   input logic Clk,
   input logic Rst,
   input logic Clear,
   priority_decoder_buf_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   idx_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push, pop;
   onehot_t          head_oh, pend;
   assign bus.InReady  = cnt_q != CNT_W'(DEPTH);
   assign bus.OutValid = cnt_q != '0;
   assign push = bus.InValid && bus.InReady;
   assign pop  = bus.OutValid && bus.OutReady;
   always_comb begin
      wr_d  = Clear ? '0 : wr_q + PTR_W'(push);
      rd_d  = Clear ? '0 : rd_q + PTR_W'(pop);
      cnt_d = Clear ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   // storage is deliberately left unreset; only occupied slots are ever observed
   always_ff @(posedge Clk) begin
      if (push && !Clear && !Rst) mem_q[wr_q] <= bus.In;
   end
   onehot_decoder u_dec (.idx_i(mem_q[rd_q]), .onehot_o(head_oh));
   assign bus.Out = bus.OutValid ? head_oh : '0;
   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++)
         if (CNT_W'(i) < cnt_q) pend |= idx_to_onehot(mem_q[rd_q + PTR_W'(i)]);
   end
   assign bus.Pending = pend;
   assign bus.Count   = cnt_q;
endmodule

// File: tb/tb_priority_decoder_buf.sv
// tb_priority_decoder_buf: directed self-checking bench for priority_decoder_buf
module tb_priority_decoder_buf;
   logic clk = 0, rst = 1, clear = 0;
   int   passed = 0, total = 0;
   priority_decoder_buf_if bus ();
   priority_decoder_buf dut (.Clk(clk), .Rst(rst), .Clear(clear), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   initial begin
      bus.In = '0;
      bus.InValid = 0;
      bus.OutReady = 0;
      step();
      step();
      rst = 0;
      chk("rst_count", 32'(bus.Count), 0);
      chk("rst_outvalid", 32'(bus.OutValid), 0);
      chk("rst_out", 32'(bus.Out), 0);
      chk("rst_inready", 32'(bus.InReady), 1);
      chk("rst_pending", 32'(bus.Pending), 0);
      bus.In = 3'd2; bus.InValid = 1; bus.OutReady = 1;
      step();
      chk("pass_out", 32'(bus.Out), 32'h04);
      chk("pass_valid", 32'(bus.OutValid), 1);
      bus.InValid = 0;
      step();
      chk("pass_count", 32'(bus.Count), 0);
      chk("pass_valid_off", 32'(bus.OutValid), 0);
      bus.OutReady = 0; bus.InValid = 1;
      bus.In = 3'd0; step();
      bus.In = 3'd5; step();
      bus.In = 3'd6; step();
      bus.In = 3'd7; step();
      chk("fill_count", 32'(bus.Count), 4);
      chk("fill_inready", 32'(bus.InReady), 0);
      chk("fill_pending", 32'(bus.Pending), 32'hE1);
      chk("fill_out", 32'(bus.Out), 32'h01);
      bus.In = 3'd3; step();
      chk("full_hold_count", 32'(bus.Count), 4);
      chk("full_hold_out", 32'(bus.Out), 32'h01);
      bus.OutReady = 1; step();
      chk("drain_out1", 32'(bus.Out), 32'h20);
      chk("drain_count1", 32'(bus.Count), 3);
      step();
      bus.InValid = 0;
      chk("drain_out2", 32'(bus.Out), 32'h40);
      chk("drain_count2", 32'(bus.Count), 3);
      step();
      chk("drain_out3", 32'(bus.Out), 32'h80);
      step();
      chk("drain_out4", 32'(bus.Out), 32'h08);
      chk("drain_count4", 32'(bus.Count), 1);
      step();
      chk("drain_empty", 32'(bus.Count), 0);
      bus.OutReady = 0; bus.In = 3'd4; bus.InValid = 1; step();
      chk("sim_head", 32'(bus.Out), 32'h10);
      bus.In = 3'd1; bus.OutReady = 1; step();
      chk("sim_count", 32'(bus.Count), 1);
      chk("sim_out", 32'(bus.Out), 32'h02);
      chk("sim_pending", 32'(bus.Pending), 32'h02);
      for (int i = 0; i < 10; i++) begin
         bus.In = 3'(i % 8); bus.InValid = 1; bus.OutReady = 1;
         step();
         chk($sformatf("wrap_out%0d", i), 32'(bus.Out), 32'h1 << (i % 8));
         chk($sformatf("wrap_count%0d", i), 32'(bus.Count), 1);
      end
      bus.InValid = 0; step();
      chk("wrap_drained", 32'(bus.Count), 0);
      bus.OutReady = 0; bus.InValid = 1;
      bus.In = 3'd1; step();
      bus.In = 3'd2; step();
      bus.In = 3'd3; step();
      chk("pre_clear_count", 32'(bus.Count), 3);
      chk("pre_clear_pending", 32'(bus.Pending), 32'h0E);
      clear = 1; bus.In = 3'd7; step();
      clear = 0; bus.InValid = 0;
      chk("clear_count", 32'(bus.Count), 0);
      chk("clear_valid", 32'(bus.OutValid), 0);
      chk("clear_pending", 32'(bus.Pending), 0);
      chk("clear_out", 32'(bus.Out), 0);
      step();
      chk("clear_no7", 32'(bus.Count), 0);
      bus.In = 3'd5; bus.InValid = 1; step();
      bus.In = 3'd6; step();
      bus.InValid = 0;
      chk("post_clear_out", 32'(bus.Out), 32'h20);
      chk("post_clear_pending", 32'(bus.Pending), 32'h60);
      chk("stall_count", 32'(bus.Count), 2);
      rst = 1; step();
      rst = 0;
      chk("midrst_count", 32'(bus.Count), 0);
      chk("midrst_valid", 32'(bus.OutValid), 0);
      chk("midrst_out", 32'(bus.Out), 0);
      chk("midrst_pending", 32'(bus.Pending), 0);
      chk("midrst_inready", 32'(bus.InReady), 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
